// File: rtl/capture_sequencer_if.sv
// Sample RAM port and the streamed-sample handshake between the sequencer and the datapath.
// The master side is the sequencer; the slave side is the RAM plus the sample consumer.
interface capture_sequencer_if #(
    parameter int ADDR_W = 18
);
    logic              ram_we;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output ram_we, ram_en, ram_addr, ram_din, rd_data, rd_valid,
        input  ram_dout, rd_ready
    );

    modport slave (
        input  ram_we, ram_en, ram_addr, ram_din, rd_data, rd_valid,
        output ram_dout, rd_ready
    );
endinterface

// File: rtl/capture_sequencer.sv
// Programs and arms the capture engine, waits for completion, then streams the circular
// sample buffer out oldest-first through a 2-entry FIFO while owning the RAM port.
//
//  state  | meaning
//  IDLE   | engine owns RAM, waiting for cmd_start
//  CONFIG | trigger/pretrig configs latched and stable
//  ARM    | cap_control[0] held high for ARM_CYCLES cycles
//  WAIT   | waiting for engine done (cap_status[2])
//  READ   | sequencer owns RAM, unrolling buffer from end_addr+1
//  FINISH | one-cycle done pulse
module capture_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int ARM_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [31:0]          cfg_trigger,
    input  logic [ADDR_W-1:0]    cfg_pretrig,
    output logic [31:0]          cap_control,
    output logic [31:0]          cap_config0,
    output logic [31:0]          cap_config1,
    input  logic [31:0]          cap_status,
    input  logic [ADDR_W-1:0]    cap_end_addr,
    input  logic                 cap_we,
    input  logic                 cap_en,
    input  logic [ADDR_W-1:0]    cap_addr,
    input  logic [7:0]           cap_dout,
    capture_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        ARM    = 3'd2,
        WAIT   = 3'd3,
        READ   = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam int                ARM_W    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0]  ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
    localparam logic [ARM_W-1:0]  ARM_ONE  = ARM_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_nxt;
    logic [ARM_W-1:0]  arm_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   xfer_left;
    logic              infl;
    logic [1:0]        occ;
    logic              wr_ptr, rd_ptr;
    logic [7:0]        fifo_mem [0:1];
    logic              abort_q;
    logic [31:0]       cfg0;
    logic [ADDR_W-1:0] cfg1;

    logic              abort_take;
    logic              pop;
    logic              issue;
    logic [1:0]        room_used;
    logic              own_ram;
    logic              unused_status;

    assign unused_status = ^{cap_status[31:3], cap_status[1:0]};

    always_comb begin
        state_nxt  = state_q;
        abort_take = cmd_abort && (state_q != IDLE);
        pop        = (occ != 2'd0) && bus.rd_ready;
        // a slot freed by this cycle's pop may be refilled immediately, keeping one sample per cycle
        room_used  = occ + {1'b0, infl} - {1'b0, pop};
        issue      = (state_q == READ) && (issue_left != '0) && (room_used < 2'd2);
        case (state_q)
            IDLE:    if (cmd_start) state_nxt = CONFIG;
            CONFIG:  state_nxt = ARM;
            ARM:     if (arm_cnt == '0) state_nxt = WAIT;
            WAIT:    if (cap_status[2]) state_nxt = READ;
            READ:    if (pop && (xfer_left == CNT_ONE)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_take) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            arm_cnt    <= '0;
            rd_addr    <= '0;
            issue_left <= '0;
            xfer_left  <= '0;
            infl       <= 1'b0;
            occ        <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            abort_q    <= 1'b0;
            cfg0       <= '0;
            cfg1       <= '0;
        end else begin
            state_q <= state_nxt;
            abort_q <= abort_take;
            if ((state_q == IDLE) && cmd_start) begin
                cfg0 <= cfg_trigger;
                cfg1 <= cfg_pretrig;
            end
            if (state_q == CONFIG)
                arm_cnt <= ARM_LOAD;
            else if ((state_q == ARM) && (arm_cnt != '0))
                arm_cnt <= arm_cnt - ARM_ONE;
            if (abort_take) begin
                infl       <= 1'b0;
                occ        <= 2'd0;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                issue_left <= '0;
                xfer_left  <= '0;
            end else begin
                infl <= issue;
                if ((state_q == WAIT) && cap_status[2]) begin
                    rd_addr    <= cap_end_addr + ADDR_ONE;
                    issue_left <= DEPTH_C;
                    xfer_left  <= DEPTH_C;
                end
                if (issue) begin
                    rd_addr    <= rd_addr + ADDR_ONE;
                    issue_left <= issue_left - CNT_ONE;
                end
                if (infl) wr_ptr <= ~wr_ptr;
                if (pop) begin
                    rd_ptr    <= ~rd_ptr;
                    xfer_left <= xfer_left - CNT_ONE;
                end
                occ <= occ + {1'b0, infl} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (infl) fifo_mem[wr_ptr] <= bus.ram_dout;
    end

    assign own_ram      = (state_q == READ);
    assign bus.ram_we   = own_ram ? 1'b0    : cap_we;
    assign bus.ram_en   = own_ram ? issue   : cap_en;
    assign bus.ram_addr = own_ram ? rd_addr : cap_addr;
    assign bus.ram_din  = own_ram ? 8'h00   : cap_dout;

    assign bus.rd_valid = (occ != 2'd0);
    assign bus.rd_data  = (occ != 2'd0) ? fifo_mem[rd_ptr] : 8'h00;

    assign cap_control = {30'd0, abort_q, (state_q == ARM)};
    assign cap_config0 = cfg0;
    assign cap_config1 = {{(32-ADDR_W){1'b0}}, cfg1};
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);
    assign state       = state_q;

endmodule
